// File: rtl/get_packet_gen.sv
// -----------------------------------------------------------------------------
// get_packet_gen
// Host-side USB receive packet parser. Consumes the SIE receive byte stream,
// classifies the packet by PID (handshake or data), forwards data payload to
// the RX FIFO while withholding the last HOLD_BYTES bytes (CRC trailer), and
// reports packet status, byte count and error flags to the transaction
// controller.
//
// Optional feature macro: GET_PACKET_PID_CHECK_EN
//   defined   : PID[7:4] must equal ~PID[3:0]; a mismatch raises pid_err.
//   undefined : no PID integrity check, pid_err tied to 0.
//
// Ports
//   clk                 in   clock
//   rst                 in   synchronous active-high reset
//   get_packet_en       in   pulse: start receiving one packet (IDLE only)
//   rx_data_in          in   byte from the SIE
//   rx_data_valid       in   rx_data_in / rx_stream_status_in valid
//   rx_stream_status_in in   0 = PID byte, 1 = data byte, other = EOP status
//   sie_rx_timeout      in   single-cycle timeout pulse from the SIE
//   rx_fifo_full        in   RX FIFO full
//   rx_fifo_data        out  payload byte to the FIFO
//   rx_fifo_wen         out  FIFO write strobe, one cycle per byte
//   rx_packet_rdy       out  one-cycle pulse: packet finished, status valid
//   rx_pkt_status       out  {data_seq, ack, stall, nak, timeout, overflow,
//                             bitstuff_err, crc_err}
//   rx_pid              out  received PID[3:0]
//   sie_rx_timeout_en   out  enables the SIE timeout counter
//   rx_byte_cnt         out  payload bytes written to or dropped at the FIFO
//   babble              out  payload exceeded MAX_PKT_BYTES
//   pid_err             out  PID integrity check failed
// -----------------------------------------------------------------------------
module get_packet_gen #(
  parameter int DATA_W        = 8,
  parameter int HOLD_BYTES    = 2,
  parameter int MAX_PKT_BYTES = 64,
  parameter int CNT_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              get_packet_en,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_stream_status_in,
  input  logic              sie_rx_timeout,
  input  logic              rx_fifo_full,
  output logic [DATA_W-1:0] rx_fifo_data,
  output logic              rx_fifo_wen,
  output logic              rx_packet_rdy,
  output logic [7:0]        rx_pkt_status,
  output logic [3:0]        rx_pid,
  output logic              sie_rx_timeout_en,
  output logic [CNT_W-1:0]  rx_byte_cnt,
  output logic              babble,
  output logic              pid_err
);

  // Bit positions inside rx_pkt_status.
  localparam int B_CRC   = 0;
  localparam int B_BSTF  = 1;
  localparam int B_OVF   = 2;
  localparam int B_TMO   = 3;
  localparam int B_NAK   = 4;
  localparam int B_STALL = 5;
  localparam int B_ACK   = 6;
  localparam int B_DSEQ  = 7;

  // Hold occupancy counter only has to reach HOLD_BYTES (at most 4).
  localparam int                HCW      = 3;
  localparam logic [HCW-1:0]    HOLD_CNT = HCW'(HOLD_BYTES);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_PKT_BYTES);

  // Only the low PID nibble is needed unless the integrity check is built in.
`ifdef GET_PACKET_PID_CHECK_EN
  localparam int PID_KEEP = 8;
`else
  localparam int PID_KEEP = 4;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PID,
    ST_CHK_PID,
    ST_HSHK,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t               stateReg, stateNext;

  logic [DATA_W-1:0]    fifoDataReg, fifoDataNext;
  logic                 wenReg, wenNext;
  logic                 rdyReg, rdyNext;
  logic [7:0]           statusReg, statusNext;
  logic [3:0]           pidReg, pidNext;
  logic                 toEnReg, toEnNext;
  logic [CNT_W-1:0]     cntReg, cntNext;
  logic                 babbleReg, babbleNext;
  logic                 pidErrReg, pidErrNext;

  // PID byte captured in WAIT_PID and evaluated in CHK_PID.
  logic [PID_KEEP-1:0]  pidByteReg, pidByteNext;
  logic                 pidStsOkReg, pidStsOkNext;

  // Trailer hold register: entry 0 is the oldest byte once the register fills.
  logic [DATA_W-1:0]    holdReg  [HOLD_BYTES];
  logic [DATA_W-1:0]    holdNext [HOLD_BYTES];
  logic [HCW-1:0]       holdCntReg, holdCntNext;
  logic                 loadEn;
  logic                 shiftEn;

  // Packet-phase handling is shared between the HSHK/DATA states and the
  // CHK_PID cycle that routes into them, so a byte arriving right after the
  // PID is not lost and the stream runs at one byte per cycle.
  logic                 doHshk;
  logic                 doData;

  // ---------------------------------------------------------------------------
  // Hold register next-state: partial fill writes the next free slot, a full
  // register shifts towards entry 0 and takes the new byte at the top.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < HOLD_BYTES; gi++) begin : g_hold
    if (gi == HOLD_BYTES - 1) begin : g_top
      assign holdNext[gi] = (shiftEn || (loadEn && holdCntReg == HCW'(gi)))
                            ? rx_data_in : holdReg[gi];
    end else begin : g_low
      assign holdNext[gi] = shiftEn ? holdReg[gi+1]
                          : (loadEn && holdCntReg == HCW'(gi)) ? rx_data_in
                          : holdReg[gi];
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= ST_IDLE;
      fifoDataReg <= '0;
      wenReg      <= 1'b0;
      rdyReg      <= 1'b0;
      statusReg   <= '0;
      pidReg      <= '0;
      toEnReg     <= 1'b0;
      cntReg      <= '0;
      babbleReg   <= 1'b0;
      pidErrReg   <= 1'b0;
      pidByteReg  <= '0;
      pidStsOkReg <= 1'b0;
      holdCntReg  <= '0;
      for (int i = 0; i < HOLD_BYTES; i++) begin
        holdReg[i] <= '0;
      end
    end else begin
      stateReg    <= stateNext;
      fifoDataReg <= fifoDataNext;
      wenReg      <= wenNext;
      rdyReg      <= rdyNext;
      statusReg   <= statusNext;
      pidReg      <= pidNext;
      toEnReg     <= toEnNext;
      cntReg      <= cntNext;
      babbleReg   <= babbleNext;
      pidErrReg   <= pidErrNext;
      pidByteReg  <= pidByteNext;
      pidStsOkReg <= pidStsOkNext;
      holdCntReg  <= holdCntNext;
      for (int i = 0; i < HOLD_BYTES; i++) begin
        holdReg[i] <= holdNext[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext    = stateReg;
    fifoDataNext = fifoDataReg;
    wenNext      = 1'b0;
    rdyNext      = 1'b0;
    statusNext   = statusReg;
    pidNext      = pidReg;
    cntNext      = cntReg;
    babbleNext   = babbleReg;
    pidErrNext   = pidErrReg;
    pidByteNext  = pidByteReg;
    pidStsOkNext = pidStsOkReg;
    holdCntNext  = holdCntReg;
    loadEn       = 1'b0;
    shiftEn      = 1'b0;
    doHshk       = 1'b0;
    doData       = 1'b0;

    case (stateReg)
      ST_IDLE: begin
        if (get_packet_en) begin
          statusNext  = '0;
          pidNext     = '0;
          cntNext     = '0;
          babbleNext  = 1'b0;
          pidErrNext  = 1'b0;
          holdCntNext = '0;
          stateNext   = ST_WAIT_PID;
        end
      end

      ST_WAIT_PID: begin
        if (sie_rx_timeout) begin
          statusNext[B_TMO] = 1'b1;
          stateNext         = ST_DONE;
        end else if (rx_data_valid) begin
          pidByteNext  = rx_data_in[PID_KEEP-1:0];
          pidStsOkNext = (rx_stream_status_in == 8'd0);
          stateNext    = ST_CHK_PID;
        end
      end

      ST_CHK_PID: begin
        if (!pidStsOkReg) begin
          // First byte was not tagged as a PID: treat as a lost packet.
          statusNext[B_TMO] = 1'b1;
          stateNext         = ST_DONE;
        end else begin
          pidNext = pidByteReg[3:0];
`ifdef GET_PACKET_PID_CHECK_EN
          if (pidByteReg[7:4] != ~pidByteReg[3:0]) begin
            pidErrNext = 1'b1;
            stateNext  = ST_DONE;
          end else
`endif
          if (pidByteReg[1:0] == 2'b10) begin
            doHshk = 1'b1;
          end else if (pidByteReg[1:0] == 2'b11) begin
            doData = 1'b1;
          end else begin
            stateNext = ST_DONE;
          end
        end
      end

      ST_HSHK: doHshk = 1'b1;

      ST_DATA: doData = 1'b1;

      ST_DONE: begin
        rdyNext   = 1'b1;
        stateNext = ST_IDLE;
      end

      default: stateNext = ST_IDLE;
    endcase

    if (doHshk || doData) begin
      stateNext = doHshk ? ST_HSHK : ST_DATA;
      if (sie_rx_timeout) begin
        // Timeout beats a byte arriving in the same cycle; trailer is dropped.
        statusNext[B_TMO] = 1'b1;
        holdCntNext       = '0;
        stateNext         = ST_DONE;
      end else if (rx_data_valid) begin
        if (doHshk) begin
          statusNext[B_OVF]   = rx_data_in[2];
          statusNext[B_NAK]   = rx_data_in[3];
          statusNext[B_STALL] = rx_data_in[4];
          statusNext[B_ACK]   = rx_data_in[5];
          stateNext           = ST_DONE;
        end else if (rx_stream_status_in == 8'd1) begin
          if (holdCntReg < HOLD_CNT) begin
            loadEn      = 1'b1;
            holdCntNext = holdCntReg + 1'b1;
          end else begin
            // Oldest held byte leaves; the new byte takes its place.
            shiftEn      = 1'b1;
            fifoDataNext = holdReg[0];
            if (cntReg < MAX_CNT) begin
              if (rx_fifo_full) begin
                statusNext[B_OVF] = 1'b1;
              end else begin
                wenNext = 1'b1;
              end
            end else begin
              babbleNext = 1'b1;
            end
            // Counter stops one past the limit so babble stays visible.
            if (cntReg <= MAX_CNT) begin
              cntNext = cntReg + 1'b1;
            end
          end
        end else if (rx_stream_status_in != 8'd0) begin
          statusNext[B_CRC]  = rx_stream_status_in[0];
          statusNext[B_BSTF] = rx_stream_status_in[1];
          statusNext[B_DSEQ] = rx_stream_status_in[6];
          holdCntNext        = '0;
          stateNext          = ST_DONE;
        end
      end
    end

    toEnNext = (stateNext == ST_WAIT_PID) || (stateNext == ST_CHK_PID) ||
               (stateNext == ST_HSHK)     || (stateNext == ST_DATA);
  end

  assign rx_fifo_data      = fifoDataReg;
  assign rx_fifo_wen       = wenReg;
  assign rx_packet_rdy     = rdyReg;
  assign rx_pkt_status     = statusReg;
  assign rx_pid            = pidReg;
  assign sie_rx_timeout_en = toEnReg;
  assign rx_byte_cnt       = cntReg;
  assign babble            = babbleReg;
  assign pid_err           = pidErrReg;

endmodule

// File: tb/tb_get_packet_gen.sv
// -----------------------------------------------------------------------------
// tb_get_packet_gen
// Directed and randomised packets for get_packet_gen. Each packet is a list of
// per-cycle input steps; a reference model walks the same list using the
// packet rules (PID routing, trailer withholding, babble, timeouts) to predict
// FIFO contents and the final status outputs.
// -----------------------------------------------------------------------------
module tb_get_packet_gen;

  localparam int DATA_W = 8;
  localparam int HOLD   = 2;
  localparam int MAX    = 4;
  localparam int CNT_W  = 11;

`ifdef GET_PACKET_PID_CHECK_EN
  localparam bit PID_CHECK = 1'b1;
`else
  localparam bit PID_CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              get_packet_en = 1'b0;
  logic [DATA_W-1:0] rx_data_in = '0;
  logic              rx_data_valid = 1'b0;
  logic [7:0]        rx_stream_status_in = '0;
  logic              sie_rx_timeout = 1'b0;
  logic              rx_fifo_full = 1'b0;
  logic [DATA_W-1:0] rx_fifo_data;
  logic              rx_fifo_wen;
  logic              rx_packet_rdy;
  logic [7:0]        rx_pkt_status;
  logic [3:0]        rx_pid;
  logic              sie_rx_timeout_en;
  logic [CNT_W-1:0]  rx_byte_cnt;
  logic              babble;
  logic              pid_err;

  always #5 clk = ~clk;

  get_packet_gen #(
    .DATA_W(DATA_W), .HOLD_BYTES(HOLD), .MAX_PKT_BYTES(MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .get_packet_en(get_packet_en),
    .rx_data_in(rx_data_in), .rx_data_valid(rx_data_valid),
    .rx_stream_status_in(rx_stream_status_in), .sie_rx_timeout(sie_rx_timeout),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_data(rx_fifo_data),
    .rx_fifo_wen(rx_fifo_wen), .rx_packet_rdy(rx_packet_rdy),
    .rx_pkt_status(rx_pkt_status), .rx_pid(rx_pid),
    .sie_rx_timeout_en(sie_rx_timeout_en), .rx_byte_cnt(rx_byte_cnt),
    .babble(babble), .pid_err(pid_err)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [7:0] st;
    logic       full;
    logic       to;
  } step_t;

  step_t      steps[$];
  logic [7:0] gotQ[$];
  int         rdyCnt = 0;
  int         nAssert = 0;
  int         nFail = 0;

  logic [7:0] expQ[$];
  logic [7:0] expStatus;
  logic [3:0] expPid;
  int         expCnt;
  logic       expBabble;
  logic       expPidErr;

  // Collect everything the DUT hands to the FIFO, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_fifo_wen) gotQ.push_back(rx_fifo_data);
    if (rx_packet_rdy) rdyCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addStep(input logic v, input logic [7:0] d, input logic [7:0] st,
                         input logic full, input logic to);
    step_t s;
    s.v = v; s.d = d; s.st = st; s.full = full; s.to = to;
    steps.push_back(s);
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) addStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic addByte(input logic [7:0] d, input logic [7:0] st, input logic full);
    addStep(1'b1, d, st, full, 1'b0);
  endtask

  task automatic addTo();
    addStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  // Reference model: phase 0 = awaiting PID, 1 = handshake, 2 = data, 3 = over.
  task automatic modelPacket();
    int         ph;
    logic [7:0] held[$];
    logic [7:0] b;
    ph = 0;
    expQ.delete();
    expStatus = 8'h00; expPid = 4'h0; expCnt = 0; expBabble = 1'b0; expPidErr = 1'b0;
    foreach (steps[i]) begin
      if (ph == 3) break;
      if (ph == 0) begin
        if (steps[i].to) begin
          expStatus[3] = 1'b1; ph = 3;
        end else if (steps[i].v) begin
          if (steps[i].st != 8'd0) begin
            expStatus[3] = 1'b1; ph = 3;
          end else begin
            expPid = steps[i].d[3:0];
            if (PID_CHECK && (steps[i].d[7:4] != ~steps[i].d[3:0])) begin
              expPidErr = 1'b1; ph = 3;
            end else if (steps[i].d[1:0] == 2'b10) ph = 1;
            else if (steps[i].d[1:0] == 2'b11) ph = 2;
            else ph = 3;
          end
        end
      end else if (ph == 1) begin
        if (steps[i].to) begin
          expStatus[3] = 1'b1; ph = 3;
        end else if (steps[i].v) begin
          expStatus[2] = steps[i].d[2];
          expStatus[4] = steps[i].d[3];
          expStatus[5] = steps[i].d[4];
          expStatus[6] = steps[i].d[5];
          ph = 3;
        end
      end else begin
        if (steps[i].to) begin
          expStatus[3] = 1'b1; ph = 3;
        end else if (steps[i].v && steps[i].st == 8'd1) begin
          held.push_back(steps[i].d);
          if (held.size() > HOLD) begin
            b = held.pop_front();
            if (expCnt >= MAX) expBabble = 1'b1;
            else if (steps[i].full) expStatus[2] = 1'b1;
            else expQ.push_back(b);
            if (expCnt <= MAX) expCnt++;
          end
        end else if (steps[i].v && steps[i].st != 8'd0) begin
          expStatus[0] = steps[i].st[0];
          expStatus[1] = steps[i].st[1];
          expStatus[7] = steps[i].st[6];
          ph = 3;
        end
      end
    end
  endtask

  task automatic idleInputs();
    rx_data_valid = 1'b0; rx_data_in = '0; rx_stream_status_in = '0;
    rx_fifo_full = 1'b0; sie_rx_timeout = 1'b0;
  endtask

  task automatic playSteps();
    @(negedge clk);
    get_packet_en = 1'b1;
    foreach (steps[i]) begin
      @(negedge clk);
      get_packet_en = 1'b0;
      if (i == 0) check("timeout_en active", 32'(sie_rx_timeout_en), 32'd1);
      rx_data_valid       = steps[i].v;
      rx_data_in          = steps[i].d;
      rx_stream_status_in = steps[i].st;
      rx_fifo_full        = steps[i].full;
      sie_rx_timeout      = steps[i].to;
    end
    @(negedge clk);
    get_packet_en = 1'b0;
    idleInputs();
  endtask

  task automatic runPacket(input string tag);
    int base;
    int rb;
    int w;
    base = gotQ.size();
    rb   = rdyCnt;
    modelPacket();
    playSteps();
    w = 0;
    while (rdyCnt == rb && w < 30) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check({tag, " rdy pulses"}, 32'(rdyCnt - rb), 32'd1);
    check({tag, " status"}, 32'(rx_pkt_status), 32'(expStatus));
    check({tag, " pid"}, 32'(rx_pid), 32'(expPid));
    check({tag, " byte_cnt"}, 32'(rx_byte_cnt), 32'(expCnt));
    check({tag, " babble"}, 32'(babble), 32'(expBabble));
    check({tag, " pid_err"}, 32'(pid_err), 32'(expPidErr));
    check({tag, " timeout_en idle"}, 32'(sie_rx_timeout_en), 32'd0);
    check({tag, " write count"}, 32'(gotQ.size() - base), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      check({tag, " fifo byte"}, 32'(gotQ[base+i]), 32'(expQ[i]));
    end
    $display("pkt %s: steps=%0d status=%02h pid=%0h cnt=%0d babble=%0b pid_err=%0b writes=%0d",
             tag, steps.size(), rx_pkt_status, rx_pid, rx_byte_cnt, babble, pid_err,
             gotQ.size() - base);
  endtask

  initial begin
    int         rb;
    logic [3:0] pidLow;
    logic [7:0] pidByte;
    int         kind;
    int         nb;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset fifo_data", 32'(rx_fifo_data), 32'd0);
    check("reset wen", 32'(rx_fifo_wen), 32'd0);
    check("reset rdy", 32'(rx_packet_rdy), 32'd0);
    check("reset status", 32'(rx_pkt_status), 32'd0);
    check("reset pid", 32'(rx_pid), 32'd0);
    check("reset timeout_en", 32'(sie_rx_timeout_en), 32'd0);
    check("reset cnt", 32'(rx_byte_cnt), 32'd0);
    check("reset babble", 32'(babble), 32'd0);
    check("reset pid_err", 32'(pid_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Timeout while waiting for the PID
    steps.delete(); addIdle(10); addTo();
    runPacket("wait timeout");
    check("wait timeout status const", 32'(rx_pkt_status), 32'h08);
    check("wait timeout cnt const", 32'(rx_byte_cnt), 32'd0);

    // ACK handshake
    steps.delete(); addByte(8'hD2, 8'd0, 1'b0); addByte(8'h20, 8'd1, 1'b0); addTo();
    runPacket("ack");
    check("ack status const", 32'(rx_pkt_status), 32'h40);
    check("ack pid const", 32'(rx_pid), 32'h2);

    // Data packet, CRC16 withheld
    steps.delete(); addByte(8'hC3, 8'd0, 1'b0);
    for (int i = 1; i <= 5; i++) addByte(8'(i), 8'd1, 1'b0);
    addByte(8'h00, 8'h40, 1'b0); addTo();
    runPacket("data5");
    check("data5 status const", 32'(rx_pkt_status), 32'h80);
    check("data5 cnt const", 32'(rx_byte_cnt), 32'd3);

    // FIFO full while byte 02 leaves the hold register (pushed by byte 04)
    steps.delete(); addByte(8'hC3, 8'd0, 1'b0);
    for (int i = 1; i <= 5; i++) addByte(8'(i), 8'd1, i == 4);
    addByte(8'h00, 8'h40, 1'b0); addTo();
    runPacket("overflow");
    check("overflow status const", 32'(rx_pkt_status), 32'h84);

    // Babble: 8 payload bytes against a 4-byte limit
    steps.delete(); addByte(8'hC3, 8'd0, 1'b0);
    for (int i = 1; i <= 8; i++) addByte(8'(8'h10 + i), 8'd1, 1'b0);
    addByte(8'h00, 8'h40, 1'b0); addTo();
    runPacket("babble");
    check("babble flag const", 32'(babble), 32'd1);
    check("babble cnt const", 32'(rx_byte_cnt), 32'd5);

    // Timeout and valid byte in the same cycle mid-payload
    steps.delete(); addByte(8'hC3, 8'd0, 1'b0);
    addByte(8'hAA, 8'd1, 1'b0); addByte(8'hBB, 8'd1, 1'b0); addByte(8'hCC, 8'd1, 1'b0);
    addStep(1'b1, 8'hDD, 8'd1, 1'b0, 1'b1);
    runPacket("tmo vs byte");
    check("tmo vs byte status const", 32'(rx_pkt_status), 32'h08);

    // PID with mismatched check nibble
    steps.delete(); addByte(8'hC2, 8'd0, 1'b0); addByte(8'h20, 8'd1, 1'b0); addTo();
    runPacket("pid C2");
    if (PID_CHECK) check("pid C2 err const", 32'(pid_err), 32'd1);
    else check("pid C2 hshk const", 32'(rx_pkt_status), 32'h40);

    // Reset in the middle of a data packet: no rdy pulse, outputs cleared
    steps.delete(); addByte(8'hC3, 8'd0, 1'b0);
    addByte(8'h11, 8'd1, 1'b0); addByte(8'h22, 8'd1, 1'b0); addByte(8'h33, 8'd1, 1'b0);
    rb = rdyCnt;
    playSteps();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset cnt", 32'(rx_byte_cnt), 32'd0);
    check("midreset timeout_en", 32'(sie_rx_timeout_en), 32'd0);
    check("midreset status", 32'(rx_pkt_status), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset no rdy", 32'(rdyCnt - rb), 32'd0);
    $display("pkt midreset: aborted, rdy pulses=%0d", rdyCnt - rb);

    // Randomised packets
    for (int n = 0; n < 40; n++) begin
      steps.delete();
      addIdle($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addTo();
      kind = $urandom_range(0, 3);
      if (kind == 0) pidLow = {2'($urandom_range(0, 3)), 2'b10};
      else if (kind == 3) pidLow = 4'($urandom_range(0, 15));
      else pidLow = {2'($urandom_range(0, 3)), 2'b11};
      pidByte = {~pidLow, pidLow};
      if ($urandom_range(0, 7) == 0) pidByte[7:4] = 4'($urandom_range(0, 15));
      addByte(pidByte, ($urandom_range(0, 9) == 0) ? 8'd2 : 8'd0, 1'b0);
      nb = $urandom_range(0, 9);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 3) == 0) addIdle(1);
        addStep(1'b1, 8'($urandom), ($urandom_range(0, 11) == 0) ? 8'd0 : 8'd1,
                $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 4) != 0) addByte(8'($urandom), 8'($urandom_range(2, 255)), 1'b0);
      addTo();
      runPacket("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/get_packet_gen.md
Name: get_packet_gen

Overview:
Parametrised host-side USB receive packet parser. It consumes the byte stream from the SIE receiver, classifies packets by PID (handshake or data) and writes data payload into the RX FIFO. It withholds the last HOLD_BYTES bytes (CRC trailer) from the FIFO and produces the packet status byte, byte count and error flags for the host transaction controller. It is the successor of the fixed 2-byte-hold receiver, adding a configurable trailer depth, payload counting, babble detection, in-packet timeout and optional PID integrity checking.

Parameters:
DATA_W, 8, width of the stream and FIFO data.
HOLD_BYTES, 2, trailer bytes withheld from the FIFO (2 = CRC16); legal range 1..4.
MAX_PKT_BYTES, 64, maximum payload bytes before babble is flagged.
CNT_W, 11, width of the payload byte counter; must satisfy 2^CNT_W > MAX_PKT_BYTES+HOLD_BYTES.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
get_packet_en  in  1  pulse: start receiving one packet
rx_data_in  in  DATA_W  byte from SIE
rx_data_valid  in  1  rx_data_in/rx_stream_status_in valid this cycle
rx_stream_status_in  in  8  0 = PID byte, 1 = data byte, any other value = end-of-packet status byte
sie_rx_timeout  in  1  single-cycle timeout pulse from SIE
rx_fifo_full  in  1  RX FIFO full
rx_fifo_data  out  DATA_W  payload byte to FIFO
rx_fifo_wen  out  1  FIFO write strobe, one cycle per byte
rx_packet_rdy  out  1  one-cycle pulse: packet finished, status valid
rx_pkt_status  out  8  {data_seq, ack, stall, nak, timeout, overflow, bitstuff_err, crc_err}
rx_pid  out  4  received PID[3:0]
sie_rx_timeout_en  out  1  enables the SIE timeout counter
rx_byte_cnt  out  CNT_W  payload bytes written to or dropped at the FIFO
babble  out  1  payload exceeded MAX_PKT_BYTES
pid_err  out  1  PID check failed (feature-dependent)

Behaviour:
- Reset: every output is 0, the hold register is cleared and the FSM goes to IDLE. Reset mid-packet aborts immediately with no rdy pulse.
- All outputs are registered. rx_pkt_status, rx_pid, rx_byte_cnt, babble and pid_err stay stable from the rdy pulse until the next accepted get_packet_en.
- IDLE: sie_rx_timeout_en=0. On get_packet_en, clear all flags and the counter, then go to WAIT_PID. get_packet_en is ignored in every other state.
- WAIT_PID: sie_rx_timeout_en=1. sie_rx_timeout (priority over valid) sets timeout and goes to DONE. A valid byte is captured and the FSM goes to CHK_PID.
- CHK_PID: a stream status other than 0 sets timeout and goes to DONE. Otherwise latch rx_pid and check the PID (see feature).
  - PID[1:0]=10 goes to HSHK.
  - PID[1:0]=11 goes to DATA.
  - Any other value goes to DONE.
- HSHK: the next valid byte sets overflow=b[2], nak=b[3], stall=b[4], ack=b[5], then goes to DONE.
- DATA: on each valid byte with status 1:
  - While fewer than HOLD_BYTES bytes are held, shift the byte in.
  - Otherwise, one cycle later, output the oldest held byte and shift the new byte in. If rx_fifo_full=0 and babble=0, pulse rx_fifo_wen with rx_fifo_data = oldest byte. If rx_fifo_full=1, set overflow and drop the byte.
  - rx_byte_cnt increments for every byte leaving the hold register, whether written or dropped.
- Babble: when rx_byte_cnt reaches MAX_PKT_BYTES and another byte leaves the hold register, set babble. From then on, suppress FIFO writes and keep consuming bytes until the status byte. rx_byte_cnt saturates at MAX_PKT_BYTES+1.
- Status byte (status not 0 or 1) in DATA: set crc_err=b[0], bitstuff_err=b[1], data_seq=b[6]. Held bytes are discarded and the FSM goes to DONE.
- In-packet timeout: sie_rx_timeout_en stays 1 through HSHK/DATA. A timeout pulse there sets timeout, discards held bytes and goes to DONE. If a timeout and a valid byte arrive in the same cycle, the timeout wins.
- DONE: pulse rx_packet_rdy for one cycle, then go to IDLE.
- Throughput: one byte accepted per cycle. The write decision for byte N overlaps capture of byte N+1, with no bubbles.

Optional Feature:
Macro: GET_PACKET_PID_CHECK_EN.
- Defined: CHK_PID requires PID[7:4] == ~PID[3:0]. On mismatch, set pid_err, write nothing and go to DONE; rx_pid still holds PID[3:0].
- Undefined: no check, pid_err is tied to 0, and the nibbles are not compared.

Test Plan:
- get_packet_en, no data, sie_rx_timeout after 10 cycles -> rx_packet_rdy pulse; rx_pkt_status=8'h08; rx_byte_cnt=0.
- PID 8'hD2/status 0, then byte 8'h20 -> status=8'h40 (ack); rx_pid=4'h2; no FIFO writes.
- PID 8'hC3, data 01..05/status 1, then status byte 8'h40 (CRC16 hold) -> FIFO receives 01,02,03 in order; rx_byte_cnt=3; status=8'h80.
- As above with rx_fifo_full=1 during byte 02 -> FIFO receives 01,03; overflow set; status=8'h84; rx_byte_cnt=3.
- MAX_PKT_BYTES=4, 8 data bytes, HOLD_BYTES=2 -> 4 writes; babble=1; rx_byte_cnt=5.
- With GET_PACKET_PID_CHECK_EN, PID 8'hC2 -> pid_err=1; rdy pulse; no writes. Without the macro -> handshake path taken.
